// File: rtl/serial_word_serializer.sv
// -----------------------------------------------------------------------------
// serial_word_serializer
//
// Parallel-in / serial-out word serializer intended to drive the D input of a
// downstream serial-in shift register.  One word can be held in a buffer while
// the previous word is shifting out, so back-to-back words leave no gap.
//
// Parameters
//   WIDTH      data word width, 2..32
//   MSB_FIRST  1: din[WIDTH-1] leaves first (downstream register ends up == din)
//              0: din[0] leaves first
//
// Ports
//   clk          single clock, posedge
//   rst_n        asynchronous active-low reset
//   din          parallel word
//   din_valid    din offered this cycle
//   din_ready    hold buffer can take a word (combinational, low in reset)
//   sout         serial bit (0 when sout_valid is low)
//   sout_valid   sout carries a data or parity bit
//   frame_start  first bit of a word
//   frame_end    last bit of a word (parity bit when parity is built in)
//   busy         hold buffer full or a frame in flight
//
// Build option
//   SERIALIZER_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                         bits) follows each word as one extra valid cycle.
// -----------------------------------------------------------------------------
module serial_word_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST_CNT = CW'(WIDTH - 2);

`ifdef SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Advance the shifter by one bit in the transmit direction.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {w[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, w[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Bit of a word that goes out next.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        logic b;
        if (MSB_FIRST) begin
            b = w[WIDTH-1];
        end else begin
            b = w[0];
        end
        return b;
    endfunction

    // Even parity over the data bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] hold_r, hold_nxt_s;
    logic             hold_full_r, hold_full_nxt_s;
    logic [WIDTH-1:0] shifter_r, shifter_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             sout_r, sout_nxt_s;
    logic             sout_valid_r, sout_valid_nxt_s;
    logic             frame_start_r, frame_start_nxt_s;
    logic             frame_end_r, frame_end_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             din_ready_s;
    logic             accept_s;
    logic             load_s;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_r, parity_nxt_s;
`endif

    assign din_ready_s = rst_n & ~hold_full_r;
    assign din_ready   = din_ready_s;
    assign sout        = sout_r;
    assign sout_valid  = sout_valid_r;
    assign frame_start = frame_start_r;
    assign frame_end   = frame_end_r;
    assign busy        = busy_r;

    // Next-state, datapath and next-output decode.  Output registers always
    // carry the bit being presented in the cycle after the edge, so a load
    // decides the first bit straight from the hold register.
    always_comb begin
        state_nxt_s       = state_r;
        hold_nxt_s        = hold_r;
        hold_full_nxt_s   = hold_full_r;
        shifter_nxt_s     = shifter_r;
        cnt_nxt_s         = cnt_r;
        sout_nxt_s        = 1'b0;
        sout_valid_nxt_s  = 1'b0;
        frame_start_nxt_s = 1'b0;
        frame_end_nxt_s   = 1'b0;
        load_s            = 1'b0;
        accept_s          = din_valid & din_ready_s;
`ifdef SERIALIZER_PARITY_EN
        parity_nxt_s      = parity_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt_s      = ST_PARITY;
                    sout_nxt_s       = parity_r;
                    sout_valid_nxt_s = 1'b1;
                    frame_end_nxt_s  = 1'b1;
`else
                    if (hold_full_r) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
`endif
                end else begin
                    shifter_nxt_s    = shift_once(shifter_r);
                    cnt_nxt_s        = cnt_r + CW'(1);
                    sout_nxt_s       = first_bit(shift_once(shifter_r));
                    sout_valid_nxt_s = 1'b1;
                    // Last data bit closes the frame only without a parity bit.
                    frame_end_nxt_s  = (cnt_r == PRE_LAST_CNT) & ~PARITY_EN;
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (hold_full_r) begin
                    load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Reload from hold: first bit of the new word goes straight out.
        if (load_s) begin
            state_nxt_s       = ST_SHIFT;
            shifter_nxt_s     = hold_r;
            cnt_nxt_s         = {CW{1'b0}};
            sout_nxt_s        = first_bit(hold_r);
            sout_valid_nxt_s  = 1'b1;
            frame_start_nxt_s = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity_nxt_s      = even_parity(hold_r);
`endif
        end else begin
            frame_start_nxt_s = 1'b0;
        end

        // Accept and reload are exclusive: din_ready is low while hold is full.
        if (accept_s) begin
            hold_nxt_s      = din;
            hold_full_nxt_s = 1'b1;
        end else if (load_s) begin
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end

        busy_nxt_s = hold_full_nxt_s | (state_nxt_s != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold buffer, shifter, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r        <= {WIDTH{1'b0}};
            hold_full_r   <= 1'b0;
            shifter_r     <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            sout_r        <= 1'b0;
            sout_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            hold_r        <= hold_nxt_s;
            hold_full_r   <= hold_full_nxt_s;
            shifter_r     <= shifter_nxt_s;
            cnt_r         <= cnt_nxt_s;
            sout_r        <= sout_nxt_s;
            sout_valid_r  <= sout_valid_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            frame_end_r   <= frame_end_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    // Parity of the word currently in the shifter, captured at load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_serial_word_serializer
//
// Drives an MSB-first and an LSB-first serializer (WIDTH=4) with the same
// directed stimulus.  A frame-level model (held word, current word, position
// within the frame) predicts every output each cycle; literal sequences pin
// the model for the directed cases.
// -----------------------------------------------------------------------------
module tb_serial_word_serializer;

    localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
    localparam int EXP_PERIOD = 5;
`else
    localparam int FL = W;
    localparam int EXP_PERIOD = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = 4'h0;
    logic         din_valid = 1'b0;

    logic din_ready, sout, sout_valid, frame_start, frame_end, busy;
    logic l_din_ready, l_sout, l_sout_valid, l_frame_start, l_frame_end, l_busy;

    serial_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );

    serial_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(l_din_ready), .sout(l_sout), .sout_valid(l_sout_valid),
        .frame_start(l_frame_start), .frame_end(l_frame_end), .busy(l_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic         m_hold_full = 1'b0;
    logic [W-1:0] m_hold = 4'h0;
    logic [W-1:0] m_word = 4'h0;
    int           m_pos = -1;      // index of bit on sout, -1 when none
    logic         m_acc;

    function automatic logic exp_bit(input logic [W-1:0] w, input int pos, input bit msb);
        if (pos >= W) return ^w;
        if (msb) return w[W-1-pos];
        return w[pos];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold_full = 1'b0;
            m_hold      = 4'h0;
            m_word      = 4'h0;
            m_pos       = -1;
        end else begin
            m_acc = din_valid && !m_hold_full;
            if (m_pos >= 0 && m_pos < FL - 1) begin
                m_pos++;
            end else if (m_hold_full) begin
                m_word      = m_hold;
                m_hold_full = 1'b0;
                m_pos       = 0;
            end else begin
                m_pos = -1;
            end
            if (m_acc) begin
                m_hold      = din;
                m_hold_full = 1'b1;
            end
        end
    end

    // ---------------- logs for literal checks ----------------
    bit lm[$];
    bit ll[$];
    int ts[$];
    int fs[$];
    int fe_cnt = 0;
    logic [3:0] q_down = 4'h0;

    // Downstream 4-bit serial-in shift register fed by the MSB-first stream.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_down <= 4'h0;
        else if (sout_valid) q_down <= {q_down[2:0], sout};
    end

    // Per-cycle compare against the model, plus logging.
    always @(negedge clk) begin
        logic v;
        cyc++;
        v = (m_pos >= 0);
        chk("din_ready",     din_ready,     rst_n & ~m_hold_full);
        chk("sout_valid",    sout_valid,    v);
        chk("sout",          sout,          v ? exp_bit(m_word, m_pos, 1'b1) : 1'b0);
        chk("frame_start",   frame_start,   m_pos == 0);
        chk("frame_end",     frame_end,     m_pos == FL - 1);
        chk("busy",          busy,          m_hold_full | v);
        chk("l_din_ready",   l_din_ready,   rst_n & ~m_hold_full);
        chk("l_sout_valid",  l_sout_valid,  v);
        chk("l_sout",        l_sout,        v ? exp_bit(m_word, m_pos, 1'b0) : 1'b0);
        chk("l_frame_start", l_frame_start, m_pos == 0);
        chk("l_frame_end",   l_frame_end,   m_pos == FL - 1);
        chk("l_busy",        l_busy,        m_hold_full | v);
        if (sout_valid) begin
            lm.push_back(sout);
            ts.push_back(cyc);
        end
        if (l_sout_valid) ll.push_back(l_sout);
        if (frame_start) fs.push_back(cyc);
        if (frame_end) fe_cnt++;
    end

    function automatic logic [3:0] pack4(input bit qq[$], input int s);
        if (qq.size() < s + 4) return 4'h0;
        return {qq[s], qq[s+1], qq[s+2], qq[s+3]};
    endfunction

    task automatic clear_logs();
        lm.delete(); ll.delete(); ts.delete(); fs.delete();
        fe_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    bit saw_not_ready = 1'b0;

    // Offer a word until it is taken; gives up after a bounded wait.
    task automatic send(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = din_ready;
            if (!din_ready) saw_not_ready = 1'b1;
            @(negedge clk);
            #1;
        end
        din_valid = 1'b0;
        chk("send_accepted", ok, 1'b1);
    endtask

    initial begin
        bit ok;
        // Reset state
        idle(2);
        chk("reset_din_ready", din_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(1);
        chk("post_reset_ready", din_ready, 1'b1);

        // Single word 1011
        clear_logs();
        send(4'b1011);
        idle(8);
        chk("w1011_len", lm.size(), FL);
        chk("w1011_msb_bits", pack4(lm, 0), 4'b1011);
        chk("w1011_lsb_bits", pack4(ll, 0), 4'b1101);
        chk("w1011_frame_end_count", fe_cnt, 1);
`ifdef SERIALIZER_PARITY_EN
        chk("w1011_parity", lm[4], 1'b1);
`else
        chk("w1011_downstream_q", q_down, 4'b1011);
`endif

        // Back-to-back A then 5
        clear_logs();
        send(4'hA);
        send(4'h5);
        idle(15);
        chk("b2b_len", lm.size(), 2 * FL);
        chk("b2b_bits", {pack4(lm, 0), pack4(lm, FL)}, 8'hA5);
        chk("b2b_contiguous", ts[ts.size()-1] - ts[0], 2 * FL - 1);

        // Backpressure with three words offered back to back
        clear_logs();
        saw_not_ready = 1'b0;
        send(4'h6);
        send(4'h9);
        send(4'hE);
        idle(20);
        chk("bp_ready_dropped", saw_not_ready, 1'b1);
        chk("bp_len", lm.size(), 3 * FL);
        chk("bp_order", {pack4(lm, 0), pack4(lm, FL), pack4(lm, 2*FL)}, 12'h69E);

        // Reset mid-frame
        clear_logs();
        send(4'hC);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (lm.size() >= 2);
        end
        chk("mid_two_bits_seen", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sout", sout, 1'b0);
        chk("mid_rst_valid", sout_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", din_ready, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("mid_no_partial_end", fe_cnt, 0);
        clear_logs();
        send(4'h3);
        idle(8);
        chk("after_rst_len", lm.size(), FL);
        chk("after_rst_bits", pack4(lm, 0), 4'b0011);

        // LSB-first word 0001
        clear_logs();
        send(4'b0001);
        idle(8);
        chk("lsb_0001_bits", pack4(ll, 0), 4'b1000);
        chk("msb_0001_bits", pack4(lm, 0), 4'b0001);

        // Sustained period with 0111 twice
        clear_logs();
        send(4'b0111);
        send(4'b0111);
        idle(15);
        chk("period_starts", fs.size(), 2);
        chk("period_len", fs[1] - fs[0], EXP_PERIOD);
        chk("w0111_bits", pack4(lm, 0), 4'b0111);
`ifdef SERIALIZER_PARITY_EN
        chk("w0111_parity", lm[4], 1'b1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
